// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one multi-cycle ALU between two requesters, one operation in flight.
// Optional macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins a tie (default build is round-robin).
module alu_req_arbiter #(
    parameter int N         = 8,
    parameter int M         = 4,
    parameter int LAT       = 2,
    parameter int MUL_EXTRA = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_req_valid,
    output logic [1:0]       o_req_ready,
    input  logic [2*N-1:0]   i_req_opa,
    input  logic [2*N-1:0]   i_req_opb,
    input  logic [2*M-1:0]   i_req_cmd,
    input  logic [1:0]       i_req_mode,
    input  logic [1:0]       i_req_cin,
    input  logic [3:0]       i_req_in_val,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [2*N-1:0]   o_rsp_res,
    output logic [5:0]       o_rsp_flags,
    output logic [N-1:0]     o_alu_opa,
    output logic [N-1:0]     o_alu_opb,
    output logic [M-1:0]     o_alu_cmd,
    output logic             o_alu_mode,
    output logic             o_alu_cin,
    output logic             o_alu_ce,
    output logic [1:0]       o_alu_in_val,
    input  logic [2*N-1:0]   i_alu_res,
    input  logic             i_alu_cout,
    input  logic             i_alu_of,
    input  logic             i_alu_err,
    input  logic             i_alu_e,
    input  logic             i_alu_g,
    input  logic             i_alu_l,
    output logic             o_busy
);

    localparam int CW = $clog2(LAT + MUL_EXTRA + 1);
    localparam logic [CW-1:0] C_LAT     = CW'(LAT);
    localparam logic [CW-1:0] C_LAT_MUL = CW'(LAT + MUL_EXTRA);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_gnt;
    logic          w_any;
    logic          w_gnt;
    logic          w_is_mul;
    logic [N-1:0]  w_opa;
    logic [N-1:0]  w_opb;
    logic [M-1:0]  w_cmd;
    logic          w_mode;
    logic          w_cin;
    logic [1:0]    w_in_val;

    assign w_any    = |i_req_valid;
    assign w_is_mul = o_alu_mode && ((o_alu_cmd == M'(9)) || (o_alu_cmd == M'(10)));

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Requester 0 has absolute priority whenever it is valid.
    always_comb begin
        w_gnt = 1'b0;
        if (i_req_valid[0]) begin
            w_gnt = 1'b0;
        end else begin
            w_gnt = 1'b1;
        end
    end
`else
    logic r_last_grant;

    // Round-robin: a tie goes to the requester that was not served last.
    always_comb begin
        w_gnt = 1'b0;
        if (i_req_valid == 2'b11) begin
            w_gnt = ~r_last_grant;
        end else begin
            w_gnt = i_req_valid[1];
        end
    end
`endif

    // Select the granted requester's fields and present the combinational accept.
    always_comb begin
        w_opa       = w_gnt ? i_req_opa[2*N-1:N]   : i_req_opa[N-1:0];
        w_opb       = w_gnt ? i_req_opb[2*N-1:N]   : i_req_opb[N-1:0];
        w_cmd       = w_gnt ? i_req_cmd[2*M-1:M]   : i_req_cmd[M-1:0];
        w_mode      = w_gnt ? i_req_mode[1]        : i_req_mode[0];
        w_cin       = w_gnt ? i_req_cin[1]         : i_req_cin[0];
        w_in_val    = w_gnt ? i_req_in_val[3:2]    : i_req_in_val[1:0];
        o_req_ready = 2'b00;
        if ((r_state == S_IDLE) && w_any) begin
            o_req_ready = w_gnt ? 2'b10 : 2'b01;
        end else begin
            o_req_ready = 2'b00;
        end
    end

    // Control FSM: capture the op, drive the ALU, count its latency, hold the response.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_gnt        <= 1'b0;
            o_alu_opa    <= '0;
            o_alu_opb    <= '0;
            o_alu_cmd    <= '0;
            o_alu_mode   <= 1'b0;
            o_alu_cin    <= 1'b0;
            o_alu_in_val <= 2'b00;
            o_alu_ce     <= 1'b0;
            o_rsp_valid  <= 1'b0;
            o_rsp_id     <= 1'b0;
            o_rsp_res    <= '0;
            o_rsp_flags  <= 6'd0;
            o_busy       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        o_alu_opa    <= w_opa;
                        o_alu_opb    <= w_opb;
                        o_alu_cmd    <= w_cmd;
                        o_alu_mode   <= w_mode;
                        o_alu_cin    <= w_cin;
                        o_alu_in_val <= w_in_val;
                        o_alu_ce     <= 1'b1;
                        o_busy       <= 1'b1;
                        r_gnt        <= w_gnt;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        r_last_grant <= w_gnt;
`endif
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= w_is_mul ? C_LAT_MUL : C_LAT;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        o_rsp_res   <= i_alu_res;
                        o_rsp_flags <= {i_alu_err, i_alu_of, i_alu_cout, i_alu_e, i_alu_g, i_alu_l};
                        o_rsp_id    <= r_gnt;
                        o_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_alu_ce    <= 1'b0;
                        o_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed vector table, corner sequences and a
// randomized run against a transaction-level model; a fake ALU answers only at the right cycle.
module tb_alu_req_arbiter;

    localparam int N = 8;
    localparam int M = 4;
    localparam int LAT = 2;
    localparam int MUL_EXTRA = 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     req_valid = 2'b00;
    logic [1:0]     req_ready;
    logic [2*N-1:0] req_opa = '0;
    logic [2*N-1:0] req_opb = '0;
    logic [2*M-1:0] req_cmd = '0;
    logic [1:0]     req_mode = 2'b00;
    logic [1:0]     req_cin = 2'b00;
    logic [3:0]     req_in_val = 4'd0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic           rsp_id;
    logic [2*N-1:0] rsp_res;
    logic [5:0]     rsp_flags;
    logic [N-1:0]   alu_opa, alu_opb;
    logic [M-1:0]   alu_cmd;
    logic           alu_mode, alu_cin, alu_ce;
    logic [1:0]     alu_in_val;
    logic [2*N-1:0] alu_res;
    logic           alu_cout, alu_of, alu_err, alu_e, alu_g, alu_l;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rq;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [3:0] cmd;
        logic       mode;
        logic       cin;
        logic [1:0] inval;
        logic [15:0] res;
        logic [5:0] flags;
        int         lat;
    } vec_t;

    vec_t tbl [7];

    alu_req_arbiter #(.N(N), .M(M), .LAT(LAT), .MUL_EXTRA(MUL_EXTRA)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_opa(req_opa), .i_req_opb(req_opb), .i_req_cmd(req_cmd),
        .i_req_mode(req_mode), .i_req_cin(req_cin), .i_req_in_val(req_in_val),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
        .o_rsp_res(rsp_res), .o_rsp_flags(rsp_flags),
        .o_alu_opa(alu_opa), .o_alu_opb(alu_opb), .o_alu_cmd(alu_cmd),
        .o_alu_mode(alu_mode), .o_alu_cin(alu_cin), .o_alu_ce(alu_ce),
        .o_alu_in_val(alu_in_val),
        .i_alu_res(alu_res), .i_alu_cout(alu_cout), .i_alu_of(alu_of),
        .i_alu_err(alu_err), .i_alu_e(alu_e), .i_alu_g(alu_g), .i_alu_l(alu_l),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    function automatic bit is_mul(input logic [3:0] c, input logic md);
        return md && ((c == 4'd9) || (c == 4'd10));
    endfunction

    // {err, of, cout, e, g, l, res[15:0]} of the stand-in ALU
    function automatic logic [21:0] golden(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] c, input logic md,
                                           input logic ci, input logic [1:0] iv);
        logic [15:0] r;
        logic err, of, co, e, g, l;
        r = 16'd0; err = (iv != 2'b11); of = 1'b0; co = 1'b0; e = 1'b0; g = 1'b0; l = 1'b0;
        if (md && c == 4'd0) begin
            r = 16'(a) + 16'(b) + 16'(ci);
            co = r[8];
        end else if (is_mul(c, md)) begin
            r = 16'(a) * 16'(b);
        end else if (md && c == 4'd8) begin
            e = (a == b); g = (a > b); l = (a < b);
        end else begin
            r = {a & b, a | b} ^ {12'd0, c};
        end
        return {err, of, co, e, g, l, r};
    endfunction

    // Stand-in ALU: correct outputs only once ce has been high for the op's latency.
    logic [3:0] ce_cnt = 4'd0;
    always @(posedge clk) begin
        if (!alu_ce) ce_cnt <= 4'd0;
        else if (ce_cnt != 4'hF) ce_cnt <= ce_cnt + 4'd1;
    end

    always_comb begin : fake_alu
        logic [21:0] gv;
        int need;
        gv = golden(alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_in_val);
        need = is_mul(alu_cmd, alu_mode) ? LAT + MUL_EXTRA : LAT;
        if (int'(ce_cnt) != need) gv = ~gv;
        {alu_err, alu_of, alu_cout, alu_e, alu_g, alu_l, alu_res} = gv;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_slot(input int s, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] c, input logic md, input logic ci,
                            input logic [1:0] iv);
        req_opa[s*8 +: 8]    = a;
        req_opb[s*8 +: 8]    = b;
        req_cmd[s*4 +: 4]    = c;
        req_mode[s]          = md;
        req_cin[s]           = ci;
        req_in_val[s*2 +: 2] = iv;
    endtask

    task automatic rand_slot(input int s);
        logic [3:0] c;
        c = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) c = 4'd9 + 4'($urandom_range(0, 1));
        set_slot(s, 8'($urandom), 8'($urandom), c, 1'($urandom), 1'($urandom), 2'($urandom));
    endtask

    // Called at posedge+2 with a request already driven.
    task automatic wait_ready(output logic ok);
        int k;
        k = 0;
        while (req_ready == 2'b00 && k < 10) begin
            @(posedge clk); #2;
            k++;
        end
        ok = (req_ready != 2'b00);
    endtask

    task automatic run_one(input vec_t v);
        logic ok;
        int lat;
        @(posedge clk); #1;
        set_slot(int'(v.rq), v.opa, v.opb, v.cmd, v.mode, v.cin, v.inval);
        req_valid = 2'b00;
        req_valid[v.rq] = 1'b1;
        rsp_ready = 1'b1;
        #1;
        wait_ready(ok);
        check("vec_req_ready", req_ready, v.rq ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        req_opa = ~req_opa; req_opb = ~req_opb; req_cmd = ~req_cmd; req_in_val = ~req_in_val;
        #1;
        check("vec_ready_one_cycle", req_ready, 2'b00);
        check("vec_issue_ce", alu_ce, 1'b1);
        check("vec_alu_opa", alu_opa, v.opa);
        check("vec_alu_in_val", alu_in_val, v.inval);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #2;
            lat++;
        end
        check("vec_latency", lat, v.lat);
        check("vec_rsp_id", rsp_id, v.rq);
        check("vec_rsp_res", rsp_res, v.res);
        check("vec_rsp_flags", rsp_flags, v.flags);
        @(posedge clk); #2;
        check("vec_rsp_drop", rsp_valid, 1'b0);
        check("vec_busy_idle", busy, 1'b0);
    endtask

    task automatic tie_run(input int nops);
        int grants[$];
        int ids[$];
        logic [15:0] ress[$];
        int k, e;
        @(posedge clk); #1;
        set_slot(0, 8'd1, 8'd2, 4'd0, 1'b1, 1'b0, 2'b11);
        set_slot(1, 8'd3, 8'd4, 4'd0, 1'b1, 1'b0, 2'b11);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        k = 0;
        while (ids.size() < nops && k < 100) begin
            if (req_ready == 2'b01) grants.push_back(0);
            else if (req_ready == 2'b10) grants.push_back(1);
            if (rsp_valid) begin
                ids.push_back(int'(rsp_id));
                ress.push_back(rsp_res);
            end
            if (ids.size() < nops) begin
                @(posedge clk); #2;
            end
            k++;
        end
        req_valid = 2'b00;
        check("tie_rsp_count", ids.size(), nops);
        check("tie_grant_count", grants.size(), nops);
        for (int i = 0; i < nops; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            e = 0;
`else
            e = i % 2;
`endif
            if (i < grants.size()) check("tie_grant_order", grants[i], e);
            if (i < ids.size()) begin
                check("tie_rsp_id", ids[i], e);
                check("tie_rsp_res", ress[i], (e == 1) ? 16'd7 : 16'd3);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic stall_test();
        logic [21:0] g;
        logic ok;
        int k;
        g = golden(8'd33, 8'd44, 4'd0, 1'b1, 1'b0, 2'b11);
        @(posedge clk); #1;
        set_slot(0, 8'd33, 8'd44, 4'd0, 1'b1, 1'b0, 2'b11);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        #1;
        wait_ready(ok);
        check("stall_accept", ok, 1'b1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        #1;
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(posedge clk); #2;
            k++;
        end
        check("stall_rsp_reached", rsp_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            req_valid = 2'b11;
            #1;
            check("stall_rsp_valid", rsp_valid, 1'b1);
            check("stall_rsp_res", rsp_res, g[15:0]);
            check("stall_rsp_flags", rsp_flags, g[21:16]);
            check("stall_rsp_id", rsp_id, 1'b0);
            check("stall_no_grant", req_ready, 2'b00);
            check("stall_busy", busy, 1'b1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        #1;
        check("stall_handshake_valid", rsp_valid, 1'b1);
        @(posedge clk); #2;
        check("stall_release_valid", rsp_valid, 1'b0);
        check("stall_release_busy", busy, 1'b0);
    endtask

    task automatic rst_wait_test();
        logic ok;
        logic seen;
        @(posedge clk); #1;
        set_slot(1, 8'd6, 8'd7, 4'd9, 1'b1, 1'b0, 2'b11);
        req_valid = 2'b10;
        rsp_ready = 1'b1;
        #1;
        wait_ready(ok);
        check("rst_accept", ok, 1'b1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        check("rst_pre_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_alu_ce", alu_ce, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_alu_opa", alu_opa, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            if (rsp_valid) seen = 1'b1;
        end
        check("rst_no_response", seen, 1'b0);
        tie_run(1);
    endtask

    task automatic random_test(input int ncyc);
        logic m_busy, m_last, g, busy_now, m_id;
        int m_due;
        logic [21:0] m_exp;
        logic [1:0] exp_ready, acc, old;
        m_busy = 1'b0; m_last = 1'b1; m_due = 0; m_id = 1'b0; m_exp = '0; acc = 2'b00; g = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            old = req_valid;
            for (int i = 0; i < 2; i++) begin
                if (old[i] && acc[i]) req_valid[i] = 1'b0;
                else if (old[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                else if (!old[i] && $urandom_range(0, 2) == 0) req_valid[i] = 1'b1;
                if (!(old[i] && req_valid[i])) rand_slot(i);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            busy_now = m_busy;
            exp_ready = 2'b00;
            if (!busy_now && req_valid != 2'b00) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                g = req_valid[0] ? 1'b0 : 1'b1;
`else
                g = (req_valid == 2'b11) ? ~m_last : req_valid[1];
`endif
                exp_ready = g ? 2'b10 : 2'b01;
            end
            check("rnd_req_ready", req_ready, exp_ready);
            check("rnd_busy", busy, busy_now);
            check("rnd_rsp_valid", rsp_valid, busy_now && (c >= m_due));
            if (busy_now && c >= m_due) begin
                check("rnd_rsp_id", rsp_id, m_id);
                check("rnd_rsp_res", rsp_res, m_exp[15:0]);
                check("rnd_rsp_flags", rsp_flags, m_exp[21:16]);
                if (rsp_ready) m_busy = 1'b0;
            end
            acc = req_ready;
            if (exp_ready != 2'b00) begin
                m_exp = golden(req_opa[g*8 +: 8], req_opb[g*8 +: 8], req_cmd[g*4 +: 4],
                               req_mode[g], req_cin[g], req_in_val[g*2 +: 2]);
                m_due = c + 2 + LAT + (is_mul(req_cmd[g*4 +: 4], req_mode[g]) ? MUL_EXTRA : 0);
                m_id = g;
                m_last = g;
                m_busy = 1'b1;
            end
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b0, 8'd10,  8'd5,   4'd0,  1'b1, 1'b0, 2'b11, 16'd15,    6'b000000, 4};
        tbl[1] = '{1'b1, 8'd12,  8'd13,  4'd9,  1'b1, 1'b0, 2'b11, 16'd156,   6'b000000, 5};
        tbl[2] = '{1'b1, 8'd12,  8'd13,  4'd9,  1'b0, 1'b0, 2'b11, 16'h0C04,  6'b000000, 4};
        tbl[3] = '{1'b0, 8'd200, 8'd100, 4'd0,  1'b1, 1'b1, 2'b11, 16'd301,   6'b001000, 4};
        tbl[4] = '{1'b0, 8'd7,   8'd7,   4'd8,  1'b1, 1'b0, 2'b11, 16'd0,     6'b000100, 4};
        tbl[5] = '{1'b1, 8'd3,   8'd9,   4'd8,  1'b1, 1'b0, 2'b00, 16'd0,     6'b100001, 4};
        tbl[6] = '{1'b0, 8'd255, 8'd255, 4'd10, 1'b1, 1'b0, 2'b01, 16'd65025, 6'b100000, 5};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("reset_req_ready", req_ready, 2'b00);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_alu_ce", alu_ce, 1'b0);
        check("reset_alu_opa", alu_opa, 8'd0);
        check("reset_alu_in_val", alu_in_val, 2'b00);
        check("reset_rsp_res", rsp_res, 16'd0);
        check("reset_rsp_flags", rsp_flags, 6'd0);
        check("reset_rsp_id", rsp_id, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        tie_run(3);
        for (int i = 0; i < 7; i++) run_one(tbl[i]);
        stall_test();
        rst_wait_test();

        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        random_test(1500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
